// File: rtl/uart_pkg.sv
// Shared UART receive definitions: FSM state type, frame width and bit-timing helpers.
package uart_pkg;

  localparam int unsigned DATA_BITS        = 8;
  localparam int unsigned CLKS_PER_BIT_DEF = 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_WAIT_HIGH
  } uart_rx_state_t;

  // Cycle index within a bit period at which the line is sampled.
  function automatic int unsigned sample_half(input int unsigned cpb);
    return (cpb - 1) / 2;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input, with a configurable reset level.
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_deser.sv
// 8N1 UART receiver: oversampled mid-bit sampling into a single-entry holding register
// with valid/ready handoff, framing-error and overrun pulses.
module uart_deser
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data,
  output logic                 valid,
  input  logic                 ready,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned IDX_W = $clog2(DATA_BITS);
  localparam int unsigned HALF  = sample_half(CLKS_PER_BIT);

  localparam logic [CNT_W-1:0] HALF_C   = CNT_W'(HALF);
  localparam logic [CNT_W-1:0] LAST_C   = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

  uart_rx_state_t       state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 frame_err_q, frame_err_d;
  logic                 overrun_q, overrun_d;
  logic                 busy_q, busy_d;

  logic                 rx_s;
  logic [CNT_W-1:0]     cnt_inc_c;
  logic                 at_sample_c;
  logic                 byte_done_c;

  sync_2ff #(.RST_VAL(1'b1)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (rx),
    .q_o   (rx_s)
  );

  assign cnt_inc_c   = (cnt_q == LAST_C) ? '0 : cnt_q + CNT_W'(1);
  assign at_sample_c = (cnt_q == HALF_C);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      shift_q     <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      shift_q     <= shift_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
      busy_q      <= busy_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    shift_d     = shift_q;
    data_d      = data_q;
    valid_d     = valid_q;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;
    byte_done_c = 1'b0;

    if (valid_q && ready) valid_d = 1'b0;

    case (state_q)
      // The first low cycle is tick 0 of the start bit; with HALF==0 it is also its sample.
      ST_IDLE: begin
        cnt_d = '0;
        if (!rx_s) begin
          cnt_d   = cnt_inc_c;
          idx_d   = '0;
          state_d = (HALF_C == '0) ? ST_DATA : ST_START;
        end
      end
      ST_START: begin
        cnt_d = cnt_inc_c;
        if (at_sample_c) begin
          if (rx_s) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end else begin
            state_d = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        cnt_d = cnt_inc_c;
        if (at_sample_c) begin
          shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
          idx_d   = idx_q + IDX_W'(1);
          if (idx_q == LAST_IDX) state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        cnt_d = cnt_inc_c;
        if (at_sample_c) begin
          cnt_d = '0;
          if (rx_s) begin
            state_d     = ST_IDLE;
            byte_done_c = 1'b1;
          end else begin
            state_d     = ST_WAIT_HIGH;
            frame_err_d = 1'b1;
          end
        end
      end
      // Hold off until the line returns high so a break is not seen as a new start.
      ST_WAIT_HIGH: begin
        cnt_d = '0;
        if (rx_s) state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase

    if (byte_done_c) begin
      if (!valid_q || ready) begin
        data_d  = shift_q;
        valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end

    busy_d = (state_d != ST_IDLE);
  end

  assign data      = data_q;
  assign valid     = valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
  assign busy      = busy_q;

endmodule

// File: doc/uart_deser.md
UART_DESER -- requirements
Module: uart_deser

Interface
REQ-001 Parameter CLKS_PER_BIT, default 1, clk cycles per serial bit; legal range 1..1024.
REQ-002 clk  input  1  system clock; all logic on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 rx  input  1  serial line; idle high, 8N1 frame, LSB first; asynchronous to clk.
REQ-005 data  output  8  received byte; valid only while valid=1.
REQ-006 valid  output  1  byte available in holding register.
REQ-007 ready  input  1  consumer accepts byte when valid&&ready at a rising edge.
REQ-008 frame_err  output  1  one-cycle pulse: stop bit sampled low.
REQ-009 overrun  output  1  one-cycle pulse: completed byte dropped because holding register full.
REQ-010 busy  output  1  high whenever FSM is not IDLE.

Function
REQ-011 rx passes through a 2-flop synchronizer (rx_s) before any use; no other logic samples raw rx.
REQ-012 Bit counter cnt runs 0..CLKS_PER_BIT-1 within each bit; sample point is cnt==HALF, HALF=(CLKS_PER_BIT-1)/2 (integer division).
REQ-013 FSM states: IDLE, START, DATA, STOP, WAIT_HIGH.
REQ-014 IDLE: the first cycle rx_s==0 is start-bit tick cnt=0; if HALF==0 that cycle is also the start sample point (go DATA), else go START.
REQ-015 START: at sample point rx_s==1 -> false start, back to IDLE with no outputs; rx_s==0 -> DATA.
REQ-016 DATA: sample points fall every CLKS_PER_BIT cycles after the start sample; shift rx_s into bit position 0..7 in order; after 8th sample -> STOP.
REQ-017 STOP: at sample point rx_s==1 -> byte complete, go IDLE; rx_s==0 -> frame_err pulse next cycle, byte discarded, go WAIT_HIGH.
REQ-018 WAIT_HIGH: stay until rx_s==1, then IDLE; prevents a low stop/break being taken as a new start.
REQ-019 IDLE accepts a new start in the cycle immediately after leaving STOP (back-to-back frames at CLKS_PER_BIT=1 lose no byte).
REQ-020 Completed byte loads data and sets valid on the edge ending the stop sample cycle; rx-edge-to-valid latency = 2 sync cycles + 9.5 bit periods (rounded down to sample point) + 1.
REQ-021 valid&&ready clears valid next edge; data holds its value while valid=1.
REQ-022 Completion while valid=1 and ready=0: keep old data, drop new byte, pulse overrun one cycle.
REQ-023 Completion in same cycle as valid&&ready: load new byte, valid stays 1, no overrun.
REQ-024 frame_err and overrun are never asserted in the same cycle (framing-error bytes are never offered for load).

Reset
REQ-025 rst_n low asynchronously forces: FSM IDLE, cnt 0, shift register 0, synchronizer flops 1, data 8'h00, valid 0, frame_err 0, overrun 0, busy 0.
REQ-026 Reset mid-frame aborts the frame without any output; after release, a frame already in progress is handled per REQ-014/015 (may false-start or mis-frame; no lockup).
REQ-027 Reset release needs no idle-line guard beyond REQ-014.

Structure
REQ-028 Shared package uart_pkg holds: state enum type (uart_rx_state_t), DATA_BITS=8, default CLKS_PER_BIT constant, shared with the test pattern generator.
REQ-029 One sub-module sync_2ff (reset value parameterised, here 1) implements REQ-011; FSM, counters and holding register stay in uart_deser.

Verification
REQ-030 CLKS_PER_BIT=1, ready=1, generator sending "TEST\n" back-to-back: valid pulses carrying 0x54,0x45,0x53,0x54,0x0A in order, no frame_err/overrun.
REQ-031 CLKS_PER_BIT=16, single frame 0xA5 driven at exact bit timing: data=0xA5, valid rises at cycle predicted by REQ-020 (+/-0), busy high from start detect to stop sample.
REQ-032 CLKS_PER_BIT=16, 5-cycle low glitch on idle line: no valid, FSM back to IDLE at sample point, busy drops.
REQ-033 CLKS_PER_BIT=4, frame 0x3C with stop bit held low 20 bits then released, followed by frame 0x81: one frame_err pulse, no valid for 0x3C, then valid with 0x81.
REQ-034 ready=0, send 0x11 then 0x22: data stays 0x11, one overrun pulse at 0x22 completion; raise ready in 0x33's completion cycle -> data=0x33, valid continuously high.
REQ-035 Assert rst_n low during DATA of a 0x55 frame: all outputs at reset values within same cycle, next full frame 0x66 received correctly.
